// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - round-robin arbiter for the shared RAM write port (optional clear: RAM_WRITE_ARBITER_CLEAR_EN)
module ram_write_arbiter #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 10,
  parameter int RAM_DEPTH      = 2**NB_ADDR
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_req0_valid,
  input  logic [NB_ADDR-1:0]        i_req0_addr,
  input  logic [NB_INSTRUCTION-1:0] i_req0_data,
  output logic                      o_req0_ready,
  input  logic                      i_req1_valid,
  input  logic [NB_ADDR-1:0]        i_req1_addr,
  input  logic [NB_INSTRUCTION-1:0] i_req1_data,
  output logic                      o_req1_ready,
  output logic                      o_ram_write_enable,
  output logic [NB_ADDR-1:0]        o_ram_write_address,
  output logic [NB_INSTRUCTION-1:0] o_ram_data,
  output logic                      o_busy
);

  // The clear sequencer walks addresses 0..RAM_DEPTH-1, so the depth must fit the address space.
  if (RAM_DEPTH < 1 || RAM_DEPTH > 2**NB_ADDR) begin : g_bad_depth
    $error("ram_write_arbiter: RAM_DEPTH must be within 1..2**NB_ADDR");
  end

  // Last-grant pointer: 0 = req0 was served last, 1 = req1 was served last.
  logic last_grant;
  logic in_arb;
  logic xfer0;
  logic xfer1;

`ifdef RAM_WRITE_ARBITER_CLEAR_EN
  localparam logic [0:0]         ST_CLEAR  = 1'b0;
  localparam logic [0:0]         ST_ARB    = 1'b1;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

  logic [0:0]         state;
  logic [NB_ADDR-1:0] clear_count;
  // Set once the final clear address has been issued; the next edge hands over to ARB.
  logic               clear_last;

  assign in_arb = (state == ST_ARB);
  assign o_busy = (state == ST_CLEAR);

  // Clear sequencer: step the counter once per cycle, then leave CLEAR one cycle after the last write.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_CLEAR;
      clear_count <= '0;
      clear_last  <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clear_last) begin
        state <= ST_ARB;
      end else if (clear_count == LAST_ADDR) begin
        clear_last <= 1'b1;
      end else begin
        clear_count <= clear_count + 1'b1;
      end
    end
  end
`else
  assign in_arb = 1'b1;
  assign o_busy = 1'b0;
`endif

  // Ready is purely combinational from the valids and the pointer; held low while in reset or clearing.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (in_arb && !i_reset) begin
      o_req0_ready = i_req0_valid && (!i_req1_valid || last_grant);
      o_req1_ready = i_req1_valid && (!i_req0_valid || !last_grant);
    end
  end

  assign xfer0 = i_req0_valid && o_req0_ready;
  assign xfer1 = i_req1_valid && o_req1_ready;

  // Register the granted write (or a clear write); address/data hold when nothing is written.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_ram_write_enable  <= 1'b0;
      o_ram_write_address <= '0;
      o_ram_data          <= '0;
      last_grant          <= 1'b1;
    end else begin
      if (xfer0) begin
        o_ram_write_enable  <= 1'b1;
        o_ram_write_address <= i_req0_addr;
        o_ram_data          <= i_req0_data;
        last_grant          <= 1'b0;
      end else if (xfer1) begin
        o_ram_write_enable  <= 1'b1;
        o_ram_write_address <= i_req1_addr;
        o_ram_data          <= i_req1_data;
        last_grant          <= 1'b1;
      end else begin
        o_ram_write_enable  <= 1'b0;
      end
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
      // No transfer can happen while clearing (ready is low), so the clear write simply takes the port.
      if (state == ST_CLEAR && !clear_last) begin
        o_ram_write_enable  <= 1'b1;
        o_ram_write_address <= clear_count;
        o_ram_data          <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - directed self-checking bench for ram_write_arbiter
module tb_ram_write_arbiter;
  localparam int NI = 16;
  localparam int NA = 4;

`ifdef RAM_WRITE_ARBITER_CLEAR_EN
  localparam logic          BUSY_RST  = 1'b1;
  localparam logic [NA-1:0] IDLE_ADDR = 4'd15;
`else
  localparam logic          BUSY_RST  = 1'b0;
  localparam logic [NA-1:0] IDLE_ADDR = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [NA-1:0] a0 = '0, a1 = '0;
  logic [NI-1:0] d0 = '0, d1 = '0;
  logic          r0, r1, we, busy;
  logic [NA-1:0] waddr;
  logic [NI-1:0] wdata;
  logic [23:0]   obs;
  logic [23:0]   exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  ram_write_arbiter #(.NB_INSTRUCTION(NI), .NB_ADDR(NA)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(r1),
    .o_ram_write_enable(we), .o_ram_write_address(waddr), .o_ram_data(wdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {busy, ready0, ready1, we, addr[3:0], data[15:0]}
  assign obs = {busy, r0, r1, we, waddr, wdata};

  function automatic logic [23:0] ev(input logic b, input logic e0, input logic e1,
                                     input logic w, input logic [NA-1:0] ad, input logic [NI-1:0] dt);
    return {b, e0, e1, w, ad, dt};
  endfunction

  task automatic do_reset();
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_arb();
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_timeout: busy=%b required 0", busy);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 4'd3; a1 = 4'd5; d0 = 16'h1111; d1 = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    exp_v = ev(BUSY_RST, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state: got %h required %h", obs, exp_v); end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    v1 = 1'b1; a1 = 4'd7; d1 = 16'h00FF;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
    #1;
    exp_v = ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL clear_start: got %h required %h", obs, exp_v); end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      exp_v = ev(1'b1, 1'b0, 1'b0, 1'b1, NA'(i), 16'h0000);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clear_write_%0d: got %h required %h", i, obs, exp_v); end
    end
    @(posedge clk); #1;
    exp_v = ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL clear_done: got %h required %h", obs, exp_v); end
`else
    #1;
    exp_v = ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL no_clear_ready: got %h required %h", obs, exp_v); end
`endif
    @(posedge clk); #1;
    v1 = 1'b0; #1;
    exp_v = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h00FF);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL waiting_req_write: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    exp_v = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 16'h00FF);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL waiting_req_idle: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_single();
    do_reset();
    wait_arb();
    v0 = 1'b1; a0 = 4'd3; d0 = 16'h1234; #1;
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, IDLE_ADDR, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL single_ready: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    a0 = 4'd4; d0 = 16'hBEEF; #1;
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL single_first_write: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    v0 = 1'b0; #1;
    exp_v = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'hBEEF);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL single_second_write: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    exp_v = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 16'hBEEF);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL single_hold: got %h required %h", obs, exp_v); end
    v1 = 1'b1; a1 = 4'd9; d1 = 16'h0F0F; #1;
    exp_v = ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 16'hBEEF);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL req1_alone_ready: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    v1 = 1'b0; #1;
    exp_v = ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 16'h0F0F);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL req1_alone_write: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [NA-1:0] pa;
    logic [NI-1:0] pd;
    do_reset();
    wait_arb();
    v0 = 1'b1; a0 = 4'd1; d0 = 16'hAAAA;
    v1 = 1'b1; a1 = 4'd2; d1 = 16'h5555;
    for (int i = 0; i < 6; i++) begin
      #1;
      pa = (i % 2 == 1) ? 4'd1 : 4'd2;
      pd = (i % 2 == 1) ? 16'hAAAA : 16'h5555;
      if (i == 0) exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, IDLE_ADDR, 16'h0000);
      else        exp_v = ev(1'b0, (i % 2 == 0), (i % 2 == 1), 1'b1, pa, pd);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL contention_cycle_%0d: got %h required %h", i, obs, exp_v); end
      @(posedge clk);
    end
    #1;
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    v0 = 1'b1; v1 = 1'b1; #1;
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h5555);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pointer_after_idle: got %h required %h", obs, exp_v); end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_arb();
    v0 = 1'b1; a0 = 4'd5; d0 = 16'h0A0A;
    @(posedge clk); #1;
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0A0A);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_before_reset: got %h required %h", obs, exp_v); end
    #2 rst = 1'b1;
    #1;
    exp_v = ev(BUSY_RST, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_async_reset: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
    exp_v = ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
`else
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
`endif
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_after_release: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
`ifdef RAM_WRITE_ARBITER_CLEAR_EN
    exp_v = ev(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000);
`else
    exp_v = ev(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0A0A);
`endif
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_first_edge: got %h required %h", obs, exp_v); end
    v0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_single();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
